// File: rtl/j11bus.sv
// DCJ11 bus target decoder: routes each request to memory, I/O page, GP or IRQ ack.
// Optional target timeout counter enabled by defining J11BUS_TIMEOUT_EN.
module j11bus #(
   parameter logic [21:0] MEMSIZE = 22'h3FE000,
   parameter int          TIMEOUT = 255,
   parameter logic [15:0] GPDATA  = 16'o173000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        busreq,
   input  logic        buswr,
   input  logic        busgp,
   input  logic        busirq,
   input  logic [21:0] busaddr,
   input  logic [15:0] buswdata,
   input  logic [1:0]  buswstrb,
   input  logic [1:0]  busbs,
   output logic        busack,
   output logic [15:0] busrdata,
   output logic        buserr,
   output logic        memreq,
   output logic        memwr,
   output logic [21:0] memaddr,
   output logic [15:0] memwdata,
   output logic [1:0]  memwstrb,
   input  logic        memack,
   input  logic [15:0] memrdata,
   output logic        ioreq,
   output logic        iowr,
   output logic [12:0] ioaddr,
   output logic [15:0] iowdata,
   output logic [1:0]  iowstrb,
   input  logic        ioack,
   input  logic [15:0] iordata,
   input  logic        ioerr,
   input  logic [15:0] irqvec,
   output logic        irqack,
   output logic        gpwr,
   output logic [7:0]  gpcode
);

   typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

   state_t      state, state_nx;
   logic        wr_q;
   logic [21:0] addr_q;
   logic [15:0] wdata_q;
   logic [1:0]  wstrb_q;
   logic [15:0] rdata_q, rdata_nx;
   logic        rdata_ld;
   logic        err_q, err_nx;
   logic        irqack_q, irqack_nx;
   logic        gpwr_q, gpwr_nx;
   logic        memreq_q, memreq_nx;
   logic        ioreq_q, ioreq_nx;
   logic        is_io;
   logic        tmo;

   assign is_io = (busbs == 2'b11) || (busaddr[21:13] == 9'h1FF);

`ifdef J11BUS_TIMEOUT_EN
   logic [15:0] wait_cnt;

   // Counts wait cycles in MEM/IO; an ack in the final cycle still beats the timeout.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE || state == DONE) wait_cnt <= '0;
      else                                       wait_cnt <= wait_cnt + 16'd1;
   end

   assign tmo = (wait_cnt == 16'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign tmo            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      rdata_ld  = 1'b0;
      rdata_nx  = '0;
      err_nx    = 1'b0;
      irqack_nx = 1'b0;
      gpwr_nx   = 1'b0;
      memreq_nx = 1'b0;
      ioreq_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (busreq) begin
               if (busirq) begin
                  state_nx  = DONE;
                  rdata_ld  = 1'b1;
                  rdata_nx  = irqvec;
                  irqack_nx = 1'b1;
               end else if (busgp) begin
                  state_nx = DONE;
                  rdata_ld = !buswr;
                  rdata_nx = GPDATA;
                  gpwr_nx  = buswr;
               end else if (is_io) begin
                  state_nx = IO;
                  ioreq_nx = 1'b1;
               end else if (busaddr < MEMSIZE) begin
                  state_nx  = MEM;
                  memreq_nx = 1'b1;
               end else begin
                  state_nx = DONE;
                  err_nx   = 1'b1;
               end
            end
         end
         MEM: begin
            if (memack) begin
               state_nx = DONE;
               rdata_ld = !wr_q;
               rdata_nx = memrdata;
            end else if (tmo) begin
               state_nx = DONE;
               err_nx   = 1'b1;
            end
         end
         IO: begin
            if (ioack) begin
               state_nx = DONE;
               rdata_ld = !wr_q;
               rdata_nx = iordata;
               err_nx   = ioerr;
            end else if (tmo) begin
               state_nx = DONE;
               err_nx   = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request fields are captured only when accepted, so they stay put for the target.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         irqack_q <= 1'b0;
         gpwr_q   <= 1'b0;
         memreq_q <= 1'b0;
         ioreq_q  <= 1'b0;
      end else begin
         if (state == IDLE && busreq) begin
            wr_q    <= buswr;
            addr_q  <= busaddr;
            wdata_q <= buswdata;
            wstrb_q <= buswstrb;
         end
         if (rdata_ld) rdata_q <= rdata_nx;
         err_q    <= err_nx;
         irqack_q <= irqack_nx;
         gpwr_q   <= gpwr_nx;
         memreq_q <= memreq_nx;
         ioreq_q  <= ioreq_nx;
      end
   end

   assign busack   = (state == DONE);
   assign busrdata = rdata_q;
   assign buserr   = err_q;
   assign irqack   = irqack_q;
   assign gpwr     = gpwr_q;
   assign gpcode   = addr_q[7:0];
   assign memreq   = memreq_q;
   assign memwr    = wr_q;
   assign memaddr  = addr_q;
   assign memwdata = wdata_q;
   assign memwstrb = wstrb_q;
   assign ioreq    = ioreq_q;
   assign iowr     = wr_q;
   assign ioaddr   = addr_q[12:0];
   assign iowdata  = wdata_q;
   assign iowstrb  = wstrb_q;

endmodule

// File: tb/tb_j11bus.sv
// Bench for j11bus: transaction-level model predicts each busack, checked every cycle.
// Timeout expectations follow J11BUS_TIMEOUT_EN when it is defined for the build.
module tb_j11bus;

   localparam logic [21:0] MEMSIZE = 22'h100000;
   localparam int          TIMEOUT = 10;
   localparam logic [15:0] GPDATA  = 16'o173000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busreq = 1'b0, buswr = 1'b0, busgp = 1'b0, busirq = 1'b0;
   logic [21:0] busaddr = '0;
   logic [15:0] buswdata = '0;
   logic [1:0]  buswstrb = '0, busbs = '0;
   logic        busack, buserr;
   logic [15:0] busrdata;
   logic        memreq, memwr;
   logic [21:0] memaddr;
   logic [15:0] memwdata;
   logic [1:0]  memwstrb;
   logic        memack = 1'b0;
   logic [15:0] memrdata = '0;
   logic        ioreq, iowr;
   logic [12:0] ioaddr;
   logic [15:0] iowdata;
   logic [1:0]  iowstrb;
   logic        ioack = 1'b0, ioerr = 1'b0;
   logic [15:0] iordata = '0;
   logic [15:0] irqvec = '0;
   logic        irqack, gpwr;
   logic [7:0]  gpcode;

   j11bus #(.MEMSIZE(MEMSIZE), .TIMEOUT(TIMEOUT), .GPDATA(GPDATA)) dut (
      .clk(clk), .rst(rst),
      .busreq(busreq), .buswr(buswr), .busgp(busgp), .busirq(busirq),
      .busaddr(busaddr), .buswdata(buswdata), .buswstrb(buswstrb), .busbs(busbs),
      .busack(busack), .busrdata(busrdata), .buserr(buserr),
      .memreq(memreq), .memwr(memwr), .memaddr(memaddr), .memwdata(memwdata),
      .memwstrb(memwstrb), .memack(memack), .memrdata(memrdata),
      .ioreq(ioreq), .iowr(iowr), .ioaddr(ioaddr), .iowdata(iowdata),
      .iowstrb(iowstrb), .ioack(ioack), .iordata(iordata), .ioerr(ioerr),
      .irqvec(irqvec), .irqack(irqack), .gpwr(gpwr), .gpcode(gpcode)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int          reqCyc;
      int          ackCyc;
      logic        hasData;
      logic [15:0] rdata;
      logic        err;
      logic        irq;
      logic        gp;
      logic [7:0]  code;
      logic        mem;
      logic        io;
      logic        wr;
      logic [21:0] addr;
      logic [15:0] wdata;
      logic [1:0]  wstrb;
   } exp_t;

   exp_t        expQ[$];
   logic [15:0] modelRdata = '0;
   int          memSeen = 0, ioSeen = 0;
   int          errors = 0, checks = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Transaction outcome from the decode rules: target class, completion cycle, data and error.
   function automatic exp_t predict(input logic irq, input logic gp, input logic wr,
                                    input logic [1:0] bs, input logic [21:0] addr,
                                    input logic [15:0] wdata, input logic [1:0] wstrb,
                                    input logic [15:0] vec, input int reqCyc,
                                    input int ackDelay, input logic [15:0] ackData,
                                    input logic ackErr);
      exp_t e;
      e.reqCyc = reqCyc;  e.ackCyc = reqCyc + 1;
      e.hasData = 1'b0;   e.rdata = '0;  e.err = 1'b0;
      e.irq = 1'b0;       e.gp = 1'b0;   e.code = '0;
      e.mem = 1'b0;       e.io = 1'b0;   e.wr = wr;
      e.addr = addr;      e.wdata = wdata; e.wstrb = wstrb;
      if (irq) begin
         e.irq = 1'b1; e.hasData = 1'b1; e.rdata = vec;
      end else if (gp) begin
         if (wr) begin e.gp = 1'b1; e.code = addr[7:0]; end
         else    begin e.hasData = 1'b1; e.rdata = GPDATA; end
      end else if (bs == 2'b11 || addr[21:13] == 9'h1FF || addr < MEMSIZE) begin
         e.io      = (bs == 2'b11 || addr[21:13] == 9'h1FF);
         e.mem     = !e.io;
         e.ackCyc  = reqCyc + 2 + ackDelay;
         e.err     = e.io & ackErr;
         e.hasData = !wr;
         e.rdata   = ackData;
`ifdef J11BUS_TIMEOUT_EN
         if (ackDelay >= TIMEOUT) begin
            e.ackCyc = reqCyc + 1 + TIMEOUT; e.err = 1'b1; e.hasData = 1'b0;
         end
`endif
      end else begin
         e.err = 1'b1;
      end
      return e;
   endfunction

   // Every cycle out of reset: strobes, completions and the held read data against the model.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst) begin
         if (memreq) begin
            if (expQ.size() == 0 || !expQ[0].mem) checkOutput("unexpected memreq", memreq, 0);
            else begin
               memSeen++;
               checkOutput("memreq cycle", cyc, expQ[0].reqCyc + 1);
               checkOutput("memaddr", memaddr, expQ[0].addr);
               checkOutput("memwr", memwr, expQ[0].wr);
               if (expQ[0].wr) begin
                  checkOutput("memwdata", memwdata, expQ[0].wdata);
                  checkOutput("memwstrb", memwstrb, expQ[0].wstrb);
               end
            end
         end
         if (ioreq) begin
            if (expQ.size() == 0 || !expQ[0].io) checkOutput("unexpected ioreq", ioreq, 0);
            else begin
               ioSeen++;
               checkOutput("ioreq cycle", cyc, expQ[0].reqCyc + 1);
               checkOutput("ioaddr", ioaddr, expQ[0].addr[12:0]);
               checkOutput("iowr", iowr, expQ[0].wr);
               if (expQ[0].wr) begin
                  checkOutput("iowdata", iowdata, expQ[0].wdata);
                  checkOutput("iowstrb", iowstrb, expQ[0].wstrb);
               end
            end
         end
         if (busack) begin
            if (expQ.size() == 0) checkOutput("unexpected busack", busack, 0);
            else begin
               e = expQ.pop_front();
               if (e.hasData) modelRdata = e.rdata;
               checkOutput("busack cycle", cyc, e.ackCyc);
               checkOutput("buserr", buserr, e.err);
               checkOutput("irqack", irqack, e.irq);
               checkOutput("gpwr", gpwr, e.gp);
               if (e.gp) checkOutput("gpcode", gpcode, e.code);
               checkOutput("memreq count", memSeen, e.mem ? 1 : 0);
               checkOutput("ioreq count", ioSeen, e.io ? 1 : 0);
               memSeen = 0;
               ioSeen  = 0;
            end
         end else begin
            if (irqack || gpwr) checkOutput("pulse without busack", {irqack, gpwr}, 0);
            if (expQ.size() > 0 && cyc > expQ[0].ackCyc) begin
               checkOutput("busack missing", busack, 1);
               void'(expQ.pop_front());
               memSeen = 0;
               ioSeen  = 0;
            end
         end
         checkOutput("busrdata held", busrdata, modelRdata);
      end
   end

   task automatic doReset(input int n);
      @(negedge clk);
      rst = 1'b1;
      expQ.delete();
      modelRdata = '0;
      memSeen = 0;
      ioSeen  = 0;
      repeat (n) @(negedge clk);
      checkOutput("reset busack", busack, 0);
      checkOutput("reset busrdata", busrdata, 0);
      checkOutput("reset buserr", buserr, 0);
      checkOutput("reset strobes", {memreq, ioreq, irqack, gpwr}, 0);
      checkOutput("reset memaddr", memaddr, 0);
      rst = 1'b0;
   endtask

   // Issues one request, answers it as the addressed target would, returns in the busack cycle.
   task automatic applyStimulus(input logic irq, input logic gp, input logic wr,
                                input logic [1:0] bs, input logic [21:0] addr,
                                input logic [15:0] wdata, input logic [1:0] wstrb,
                                input int ackDelay, input logic [15:0] ackData,
                                input logic ackErr, input bit stray);
      exp_t e;
      int   ackAt, target;
      @(negedge clk);
      busirq = irq; busgp = gp; buswr = wr; busbs = bs;
      busaddr = addr; buswdata = wdata; buswstrb = wstrb;
      busreq = 1'b1;
      e = predict(irq, gp, wr, bs, addr, wdata, wstrb, irqvec, cyc, ackDelay, ackData, ackErr);
      expQ.push_back(e);
      @(negedge clk);
      busreq = 1'b0;
      target = e.ackCyc;
      if (e.mem || e.io) begin
         ackAt = e.reqCyc + 1 + ackDelay;
         if (stray) begin
            while (cyc < e.reqCyc + 2) @(negedge clk);
            busreq = 1'b1;
            @(negedge clk);
            busreq = 1'b0;
         end
         while (cyc < ackAt) @(negedge clk);
         if (e.mem) begin memack = 1'b1; memrdata = ackData; end
         else       begin ioack = 1'b1; iordata = ackData; ioerr = ackErr; end
         @(negedge clk);
         memack = 1'b0; ioack = 1'b0; ioerr = 1'b0;
         if (ackAt + 1 > target) target = ackAt + 1;
      end
      while (cyc < target) @(negedge clk);
   endtask

   task automatic resetDuringMem();
      exp_t e;
      @(negedge clk);
      busirq = 1'b0; busgp = 1'b0; buswr = 1'b0; busbs = 2'b00;
      busaddr = 22'o002000; busreq = 1'b1;
      e = predict(1'b0, 1'b0, 1'b0, 2'b00, 22'o002000, 16'h0, 2'b11, irqvec, cyc, 1000, 16'h0, 1'b0);
      expQ.push_back(e);
      @(negedge clk);
      busreq = 1'b0;
      @(negedge clk);
      doReset(2);
      repeat (4) @(negedge clk);
      checkOutput("no ack after abort", busack, 0);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      doReset(3);

      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 22'o001000, 16'h0, 2'b11, 3, 16'o012345, 1'b0, 1'b1);
      checkOutput("mem read data literal", busrdata, 16'o012345);
      checkOutput("mem read err literal", buserr, 0);

      applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 22'o17777560, 16'o000123, 2'b01, 1, 16'h0, 1'b1, 1'b0);
      checkOutput("io ioaddr literal", ioaddr, 13'o17560);
      checkOutput("io iowstrb literal", iowstrb, 2'b01);
      checkOutput("io err literal", buserr, 1);
      checkOutput("io write keeps rdata", busrdata, 16'o012345);

      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 22'h3FDFFE, 16'h0, 2'b11, 0, 16'h0, 1'b0, 1'b0);
      checkOutput("nxm err literal", buserr, 1);
      checkOutput("nxm keeps rdata", busrdata, 16'o012345);

      irqvec = 16'o000060;
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 22'o0, 16'h0, 2'b00, 0, 16'h0, 1'b0, 1'b0);
      checkOutput("irq vector literal", busrdata, 16'o000060);
      checkOutput("irqack literal", irqack, 1);

      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 22'o0, 16'h0, 2'b00, 0, 16'h0, 1'b0, 1'b0);
      checkOutput("gp read literal", busrdata, 16'o173000);

      applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 22'o000014, 16'h0, 2'b11, 0, 16'h0, 1'b0, 1'b0);
      checkOutput("gpwr literal", gpwr, 1);
      checkOutput("gpcode literal", gpcode, 8'o014);

      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, MEMSIZE - 22'd2, 16'hA55A, 2'b10, 1, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, MEMSIZE, 16'h1111, 2'b11, 0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 22'h3FE010, 16'h0, 2'b11, 2, 16'hBEEF, 1'b0, 1'b0);
      checkOutput("io page read literal", busrdata, 16'hBEEF);

      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 22'o000100, 16'h0, 2'b11, 25, 16'h7777, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 22'o000200, 16'h0, 2'b11, 9, 16'h1234, 1'b0, 1'b0);
      checkOutput("ack at limit literal", busrdata, 16'h1234);

      resetDuringMem();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 22'o003000, 16'h0, 2'b11, 2, 16'o054321, 1'b0, 1'b0);
      checkOutput("after abort read literal", busrdata, 16'o054321);

      repeat (5) @(negedge clk);
      checkOutput("queue drained", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
